// File: rtl/cpu_data_ram.sv
// cpu_data_ram
//   Synchronous 2**ADDR_W x DATA_W data memory; responder end of the cpu
//   core's data-RAM bus. Reads have a fixed one-cycle latency, writes land
//   at the sampling edge, and one access may issue every cycle.
//
//   Optional feature macro: DATA_RAM_CLEAR_EN
//     defined   - after every reset a hardware sweep writes INIT_VALUE to
//                 every word; init_busy is high while it runs and requests
//                 made meanwhile are dropped and flagged on access_err.
//     undefined - no sweep; SERVE directly after reset, init_busy and
//                 access_err tied low, contents retained across reset.
//
//   Ports
//     clk              : clock, all state changes on rising edge
//     rst_n            : synchronous active-low reset
//     ram_EN           : access request
//     ram_RW           : 1 = read, 0 = write (qualified by ram_EN)
//     ram_address_bus  : word address
//     ram_data_bus_out : write data from the cpu
//     ram_data_bus_in  : registered read data to the cpu
//     init_busy        : clear sweep in progress
//     access_err       : one-cycle pulse, request made while init_busy
module cpu_data_ram #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        DATA_W     = 4,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_EN,
    input  logic              ram_RW,
    input  logic [ADDR_W-1:0] ram_address_bus,
    input  logic [DATA_W-1:0] ram_data_bus_out,
    output logic [DATA_W-1:0] ram_data_bus_in,
    output logic              init_busy,
    output logic              access_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Set while the bus is being served; the clear sweep owns the write
    // port otherwise.
    logic              serving;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_waddr;

`ifdef DATA_RAM_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] clr_addr_q, clr_addr_d;
    logic            init_busy_q, init_busy_d;
    logic            access_err_q, access_err_d;

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        init_busy_d  = init_busy_q;
        access_err_d = 1'b0;
        clr_we       = 1'b0;
        clr_waddr    = clr_addr_q[ADDR_W-1:0];
        serving      = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we       = 1'b1;
                clr_addr_d   = clr_addr_q + 1'b1;
                access_err_d = ram_EN;
                if (clr_addr_q == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_d     = ST_SERVE;
                    init_busy_d = 1'b0;
                end
            end
            ST_SERVE: serving = 1'b1;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            init_busy_q  <= 1'b1;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            init_busy_q  <= init_busy_d;
            access_err_q <= access_err_d;
        end
    end

    assign init_busy  = init_busy_q;
    assign access_err = access_err_q;
`else
    always_comb begin
        serving   = 1'b1;
        clr_we    = 1'b0;
        clr_waddr = '0;
    end

    assign init_busy  = 1'b0;
    assign access_err = 1'b0;
`endif

    // Bus datapath: reads update the output register, writes and idles
    // leave it holding.
    always_comb begin
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        mem_waddr = ram_address_bus;
        mem_wdata = ram_data_bus_out;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_waddr;
            mem_wdata = INIT_VALUE;
        end else if (serving && ram_EN) begin
            if (ram_RW) begin
                rd_data_d = mem[ram_address_bus];
            end else begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Memory is never touched on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ram_data_bus_in = rd_data_q;

endmodule

// File: tb/tb_cpu_data_ram.sv
module tb_cpu_data_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ram_EN;
    logic       ram_RW;
    logic [7:0] ram_address_bus;
    logic [3:0] ram_data_bus_out;
    logic [3:0] ram_data_bus_in;
    logic       init_busy;
    logic       access_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  model [256];
    logic [3:0]  exp_rd;
    logic [15:0] l1, l2, l3;
    int          n;

    cpu_data_ram #(
        .ADDR_W    (8),
        .DATA_W    (4),
        .INIT_VALUE(4'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ram_EN          (ram_EN),
        .ram_RW          (ram_RW),
        .ram_address_bus (ram_address_bus),
        .ram_data_bus_out(ram_data_bus_out),
        .ram_data_bus_in (ram_data_bus_in),
        .init_busy       (init_busy),
        .access_err      (access_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ram_EN = 1'b0;
        ram_RW = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] d);
        ram_EN = 1'b1; ram_RW = 1'b0; ram_address_bus = a; ram_data_bus_out = d;
        tick();
        model[a] = d;
    endtask

    task automatic do_read(input logic [7:0] a);
        ram_EN = 1'b1; ram_RW = 1'b1; ram_address_bus = a;
        tick();
    endtask

    // Counts edges with rst_n high until init_busy drops, bounded at 300.
    task automatic count_clear(output int cnt);
        cnt = 0;
        while (cnt < 300) begin
            tick();
            cnt++;
            if (!init_busy) break;
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic fb_in);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ fb_in};
    endfunction

    initial begin
        rst_n = 1'b0;
        ram_address_bus  = '0;
        ram_data_bus_out = '0;
        idle();
        for (int i = 0; i < 256; i++) model[i] = 4'h0;

        #1;
        tick();
        tick();
        check_eq("rst_rdata", 32'(ram_data_bus_in), 32'h0);
        check_eq("rst_err",   32'(access_err), 32'h0);
`ifdef DATA_RAM_CLEAR_EN
        check_eq("rst_busy",  32'(init_busy), 32'h1);

        // First clear: read at edge 10, write 4'hF to 8'h05 at edge 20
        // (after the sweep already cleared it).
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            idle();
            if (i == 10) begin
                ram_EN = 1'b1; ram_RW = 1'b1; ram_address_bus = 8'h33;
            end
            if (i == 20) begin
                ram_EN = 1'b1; ram_RW = 1'b0; ram_address_bus = 8'h05;
                ram_data_bus_out = 4'hF;
            end
            tick();
            if (i == 10) begin
                check_eq("clr_err_rd",   32'(access_err), 32'h1);
                check_eq("clr_rd_hold",  32'(ram_data_bus_in), 32'h0);
            end
            if (i == 11) check_eq("clr_err_pulse", 32'(access_err), 32'h0);
            if (i == 20) check_eq("clr_err_wr",    32'(access_err), 32'h1);
            if (i == 255) check_eq("clr_busy_255", 32'(init_busy), 32'h1);
            if (!init_busy) begin
                n = i;
                break;
            end
        end
        idle();
        check_eq("clr_len", 32'(n), 32'd256);

        for (int a = 0; a < 256; a++) begin
            do_read(8'(a));
            check_eq($sformatf("init_rd_%02h", a), 32'(ram_data_bus_in), 32'h0);
        end
        check_eq("no_err_serve", 32'(access_err), 32'h0);
`else
        check_eq("rst_busy", 32'(init_busy), 32'h0);
        rst_n = 1'b1;

        // No sweep: the very first edge out of reset must be serviced.
        for (int a = 0; a < 256; a++) begin
            do_write(8'(a), 4'(a * 7 + 3));
        end
        for (int a = 0; a < 256; a++) begin
            do_read(8'(a));
            check_eq($sformatf("fill_rd_%02h", a), 32'(ram_data_bus_in), 32'(model[a]));
        end
        check_eq("busy_low", 32'(init_busy), 32'h0);
        check_eq("err_low",  32'(access_err), 32'h0);
`endif

        // Write-then-read, and write leaves read data holding.
        do_write(8'h3C, 4'hA);
        do_read(8'h3C);
        check_eq("raw_3c", 32'(ram_data_bus_in), 32'hA);
        do_write(8'h3C, 4'h5);
        check_eq("wr_hold", 32'(ram_data_bus_in), 32'hA);
        idle();
        tick();
        check_eq("idle_hold", 32'(ram_data_bus_in), 32'hA);
        do_read(8'h3C);
        check_eq("rd_3c_new", 32'(ram_data_bus_in), 32'h5);

        // Range ends are distinct words.
        do_write(8'hFF, 4'h7);
        do_write(8'h00, 4'h2);
        do_read(8'hFF);
        check_eq("rd_ff", 32'(ram_data_bus_in), 32'h7);
        do_read(8'h00);
        check_eq("rd_00", 32'(ram_data_bus_in), 32'h2);

        // Reset behaviour with live data.
        do_write(8'h40, 4'h9);
        do_read(8'h40);
        check_eq("rd_40_pre", 32'(ram_data_bus_in), 32'h9);
        idle();
        rst_n = 1'b0;
        tick();
        check_eq("rst2_rdata", 32'(ram_data_bus_in), 32'h0);
        rst_n = 1'b1;
`ifdef DATA_RAM_CLEAR_EN
        for (int i = 0; i < 100; i++) tick();
        check_eq("busy_at_100", 32'(init_busy), 32'h1);
        rst_n = 1'b0;
        tick();
        check_eq("rst3_busy", 32'(init_busy), 32'h1);
        rst_n = 1'b1;
        count_clear(n);
        check_eq("reclr_len", 32'(n), 32'd256);
        for (int i = 0; i < 256; i++) model[i] = 4'h0;
        do_read(8'h40);
        check_eq("rd_40_cleared", 32'(ram_data_bus_in), 32'h0);
        do_read(8'h3C);
        check_eq("rd_3c_cleared", 32'(ram_data_bus_in), 32'h0);
`else
        do_read(8'h40);
        check_eq("rd_40_kept", 32'(ram_data_bus_in), 32'h9);
`endif
        exp_rd = ram_data_bus_in;

        // Pseudo-random traffic against the array model.
        l1 = 16'hACE1;
        l2 = 16'h1D2B;
        l3 = 16'h7F31;
        for (int c = 0; c < 2000; c++) begin
            l1 = lfsr_step(l1, 1'b0);
            l2 = lfsr_step(l2, l1[15]);
            l3 = lfsr_step(l3, l2[15]);
            ram_EN           = l2[0] | l2[1];
            ram_RW           = l2[2];
            ram_address_bus  = l3[0] ? {4'h3, l1[3:0]} : l1[7:0];
            ram_data_bus_out = l3[7:4];
            if (ram_EN && ram_RW)  exp_rd = model[ram_address_bus];
            tick();
            if (ram_EN && !ram_RW) model[ram_address_bus] = ram_data_bus_out;
            check_eq($sformatf("rand_%0d", c), 32'(ram_data_bus_in), 32'(exp_rd));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
